// File: rtl/vector_pkg.sv
// Shared types, default widths and display-list word decoding for the vector display engine.
package vector_pkg;

  localparam int ADDRESSWIDTH = 8;
  localparam int DATAWIDTH    = 18;
  localparam int OUT_WIDTH    = 8;

  typedef enum logic [1:0] {
    CMD_MOVE = 2'b00,
    CMD_DRAW = 2'b01,
    CMD_END  = 2'b10
  } cmd_t;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LINE,
    CEASE,
    DONE
  } state_t;

  // The reserved code 2'b11 is folded into END so a corrupt word still stops the frame.
  function automatic cmd_t decode_cmd(input logic [1:0] cmd_bits);
    case (cmd_bits)
      2'b00:   return CMD_MOVE;
      2'b01:   return CMD_DRAW;
      default: return CMD_END;
    endcase
  endfunction

endpackage

// File: rtl/vector_display_line_draw.sv
// Bresenham line stepper: one point per clock from (x0,y0) to (x1,y1), any octant.
module line_draw #(
  parameter int OUT_WIDTH = vector_pkg::OUT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [OUT_WIDTH-1:0] x0,
  input  logic [OUT_WIDTH-1:0] y0,
  input  logic [OUT_WIDTH-1:0] x1,
  input  logic [OUT_WIDTH-1:0] y1,
  output logic [OUT_WIDTH-1:0] x,
  output logic [OUT_WIDTH-1:0] y,
  output logic                 busy,
  output logic                 done
);

  localparam int EW = OUT_WIDTH + 2;

  logic [OUT_WIDTH-1:0] xt, yt;
  logic                 sx_neg, sy_neg;
  logic signed [EW-1:0] err, dx, dy;

  logic [OUT_WIDTH-1:0] adx, ady;
  logic signed [EW-1:0] dx_init, dy_init, err_init, err_next;
  logic signed [EW:0]   e2, dx_w, dy_w;
  logic                 step_x, step_y;

  assign adx      = (x1 >= x0) ? (x1 - x0) : (x0 - x1);
  assign ady      = (y1 >= y0) ? (y1 - y0) : (y0 - y1);
  assign dx_init  = $signed({2'b00, adx});
  assign dy_init  = -$signed({2'b00, ady});
  assign err_init = dx_init + dy_init;

  // Doubled error needs one extra bit; strict compares break ties toward the major axis.
  assign e2     = {err, 1'b0};
  assign dx_w   = {dx[EW-1], dx};
  assign dy_w   = {dy[EW-1], dy};
  assign step_x = (e2 > dy_w) && (x != xt);
  assign step_y = (e2 < dx_w) && (y != yt);
  assign err_next = err + (step_x ? dy : '0) + (step_y ? dx : '0);

  always_ff @(posedge clk) begin
    // NOTE: every register here uses <= so all state updates from the same edge's old values.
    if (rst) begin
      x      <= '0;
      y      <= '0;
      xt     <= '0;
      yt     <= '0;
      sx_neg <= 1'b0;
      sy_neg <= 1'b0;
      dx     <= '0;
      dy     <= '0;
      err    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        x      <= x0;
        y      <= y0;
        xt     <= x1;
        yt     <= y1;
        sx_neg <= (x1 < x0);
        sy_neg <= (y1 < y0);
        dx     <= dx_init;
        dy     <= dy_init;
        err    <= err_init;
        busy   <= 1'b1;
      end else if (busy) begin
        if (x == xt && y == yt) begin
          busy <= 1'b0;
          done <= 1'b1;
        end else begin
          if (step_x) x <= sx_neg ? (x - OUT_WIDTH'(1)) : (x + OUT_WIDTH'(1));
          if (step_y) y <= sy_neg ? (y - OUT_WIDTH'(1)) : (y + OUT_WIDTH'(1));
          err <= err_next;
        end
      end
    end
  end

endmodule

// File: rtl/vector_display_top.sv
// Vector display engine: walks a display list in ROM and drives X/Y DAC codes.
// Defining VECTOR_BLANK_EN adds a registered beam-blank output.
module vector_display_top #(
  parameter int ADDRESSWIDTH = vector_pkg::ADDRESSWIDTH,
  parameter int DATAWIDTH    = vector_pkg::DATAWIDTH,
  parameter int OUT_WIDTH    = vector_pkg::OUT_WIDTH,
  parameter int CEASE_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DATAWIDTH-1:0]    data_in,
  output logic [ADDRESSWIDTH-1:0] addr,
  input  logic                    go_master,
  output logic                    halt,
  output logic [OUT_WIDTH-1:0]    x_ch,
  output logic [OUT_WIDTH-1:0]    y_ch
`ifdef VECTOR_BLANK_EN
  ,
  output logic                    blank
`endif
);

  import vector_pkg::*;

  localparam int CW = (CEASE_CYCLES > 1) ? $clog2(CEASE_CYCLES) : 1;
  localparam logic [CW-1:0]           DWELL_LAST = CW'(CEASE_CYCLES - 1);
  localparam logic [ADDRESSWIDTH-1:0] ADDR_LAST  = '1;

  state_t               state, state_next;
  cmd_t                 cmd;
  logic [OUT_WIDTH-1:0] word_x, word_y;
  logic [CW-1:0]        dwell_cnt;
  logic                 dwell_done;

  logic                 ld_start, ld_busy, ld_done;
  logic [OUT_WIDTH-1:0] ld_x, ld_y;

  assign cmd        = decode_cmd(data_in[DATAWIDTH-1 -: 2]);
  assign word_x     = data_in[2*OUT_WIDTH-1:OUT_WIDTH];
  assign word_y     = data_in[OUT_WIDTH-1:0];
  assign dwell_done = (dwell_cnt == DWELL_LAST);

  generate
    if (DATAWIDTH > 2*OUT_WIDTH + 2) begin : g_pad
      logic unused_pad;
      assign unused_pad = ^data_in[DATAWIDTH-3:2*OUT_WIDTH];
    end
  endgenerate

  line_draw #(.OUT_WIDTH(OUT_WIDTH)) u_line_draw (
    .clk   (clk),
    .rst   (rst),
    .start (ld_start),
    .x0    (x_ch),
    .y0    (y_ch),
    .x1    (word_x),
    .y1    (word_y),
    .x     (ld_x),
    .y     (ld_y),
    .busy  (ld_busy),
    .done  (ld_done)
  );

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    state_next = state;
    ld_start   = 1'b0;
    unique case (state)
      IDLE:  if (go_master) state_next = FETCH;
      FETCH: begin
        unique case (cmd)
          CMD_MOVE: state_next = CEASE;
          CMD_DRAW: begin
            ld_start   = 1'b1;
            state_next = LINE;
          end
          default:  state_next = DONE;
        endcase
      end
      LINE:  if (ld_done) state_next = CEASE;
      // The last ROM word ends the frame even without an END command.
      CEASE: if (dwell_done) state_next = (addr == ADDR_LAST) ? DONE : FETCH;
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      addr      <= '0;
      x_ch      <= '0;
      y_ch      <= '0;
      halt      <= 1'b0;
      dwell_cnt <= '0;
    end else begin
      state <= state_next;
      halt  <= (state_next == DONE);
      unique case (state)
        FETCH: begin
          dwell_cnt <= '0;
          if (cmd == CMD_MOVE) begin
            x_ch <= word_x;
            y_ch <= word_y;
          end
        end
        LINE: begin
          dwell_cnt <= '0;
          if (ld_busy) begin
            x_ch <= ld_x;
            y_ch <= ld_y;
          end
        end
        CEASE: begin
          if (!dwell_done)                 dwell_cnt <= dwell_cnt + CW'(1);
          else if (state_next == FETCH)    addr      <= addr + ADDRESSWIDTH'(1);
        end
        DONE:    addr <= '0;
        default: ;
      endcase
    end
  end

`ifdef VECTOR_BLANK_EN
  logic blank_next;

  // The beam stays dark while repositioning after a MOVE and lit while tracing a DRAW.
  always_comb begin
    blank_next = 1'b1;
    unique case (state_next)
      LINE:    blank_next = 1'b0;
      CEASE:   blank_next = (state == FETCH) ? 1'b1 : (state == LINE) ? 1'b0 : blank;
      default: blank_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) blank <= 1'b1;
    else     blank <= blank_next;
  end
`endif

endmodule

// File: tb/tb_vector_display_top.sv
// Self-checking bench for vector_display_top: point scoreboard, handshake, address wrap and reset abort.
module tb_vector_display_top;

  localparam int AW  = 8;
  localparam int AWB = 4;
  localparam int DW  = 18;
  localparam int OW  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [DW-1:0]  rom_a [0:255];
  logic [DW-1:0]  rom_b [0:15];
  logic [AW-1:0]  addr_a;
  logic [AWB-1:0] addr_b;
  logic           go_a = 1'b0, go_b = 1'b0;
  logic           halt_a, halt_b;
  logic [OW-1:0]  x_a, y_a, x_b, y_b;
  logic [DW-1:0]  data_a, data_b;
`ifdef VECTOR_BLANK_EN
  logic           blank_a, blank_b;
`endif

  assign data_a = rom_a[addr_a];
  assign data_b = rom_b[addr_b];

  vector_display_top #(.ADDRESSWIDTH(AW), .DATAWIDTH(DW), .OUT_WIDTH(OW), .CEASE_CYCLES(1)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_a), .addr(addr_a), .go_master(go_a),
    .halt(halt_a), .x_ch(x_a), .y_ch(y_a)
`ifdef VECTOR_BLANK_EN
    , .blank(blank_a)
`endif
  );

  vector_display_top #(.ADDRESSWIDTH(AWB), .DATAWIDTH(DW), .OUT_WIDTH(OW), .CEASE_CYCLES(1)) dut_b (
    .clk(clk), .rst(rst), .data_in(data_b), .addr(addr_b), .go_master(go_b),
    .halt(halt_b), .x_ch(x_b), .y_ch(y_b)
`ifdef VECTOR_BLANK_EN
    , .blank(blank_b)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] word(input logic [1:0] c, input int x, input int y);
    return {c, 8'(x), 8'(y)};
  endfunction

  // Scoreboard of expected distinct (x,y) points for dut_a.
  logic [15:0] sb_q[$];
  logic [15:0] last_pt   = '0;
  logic        halt_prev = 1'b0;
  int          halt_cnt  = 0;
  bit          mon_en    = 1'b0;

  task automatic push_pt(input int x, input int y);
    sb_q.push_back({8'(x), 8'(y)});
  endtask

  always @(negedge clk) begin
    if (mon_en && ({x_a, y_a} != last_pt)) begin
      if (sb_q.size() == 0) check("sb_queue_size_at_point", sb_q.size(), 1);
      else                  check("point", {x_a, y_a}, sb_q.pop_front());
    end
    if (halt_a) begin
      halt_cnt <= halt_cnt + 1;
      check("halt_one_cycle", halt_prev, 0);
    end
    last_pt   <= {x_a, y_a};
    halt_prev <= halt_a;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_halt_a(input int budget);
    for (int i = 0; i < budget; i++) begin
      tick();
      if (halt_a) break;
    end
    check("halt_a_seen", halt_a, 1);
  endtask

  task automatic load_basic();
    for (int i = 0; i < 256; i++) rom_a[i] = word(2'b10, 0, 0);
    rom_a[0] = word(2'b00, 10, 10);
    rom_a[1] = word(2'b01, 14, 12);
    rom_a[2] = word(2'b10, 0, 0);
  endtask

  task automatic push_basic();
    push_pt(10, 10); push_pt(11, 10); push_pt(12, 11); push_pt(13, 11); push_pt(14, 12);
  endtask

  int h0;

  initial begin
    for (int i = 0; i < 16; i++) rom_b[i] = word(2'b00, i + 1, 2 * i + 1);
    load_basic();

    // Reset and idle with go_master low.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("idle_a", {addr_a, x_a, y_a, halt_a}, 0);
      check("idle_b", {addr_b, x_b, y_b, halt_b}, 0);
    end

    // Single frame: MOVE, DRAW, END.
    push_basic();
    h0 = halt_cnt;
    mon_en = 1'b1;
    go_a = 1'b1;
    wait_halt_a(200);
    go_a = 1'b0;
    tick();
    check("addr_after_frame", addr_a, 0);
    repeat (4) tick();
    check("halt_count_frame", halt_cnt - h0, 1);
    check("sb_drained_frame", sb_q.size(), 0);

    // Reverse octant, vertical, zero-length and horizontal segments.
    rom_a[2] = word(2'b01, 10, 20);
    rom_a[3] = word(2'b01, 10, 17);
    rom_a[4] = word(2'b01, 10, 17);
    rom_a[5] = word(2'b01, 13, 17);
    rom_a[6] = word(2'b11, 0, 0);
    push_basic();
    push_pt(14, 13); push_pt(13, 14); push_pt(13, 15); push_pt(12, 16);
    push_pt(12, 17); push_pt(11, 18); push_pt(11, 19); push_pt(10, 20);
    push_pt(10, 19); push_pt(10, 18); push_pt(10, 17);
    push_pt(11, 17); push_pt(12, 17); push_pt(13, 17);
    h0 = halt_cnt;
    go_a = 1'b1;
    wait_halt_a(400);
    go_a = 1'b0;
    check("end_point", {x_a, y_a}, {8'd13, 8'd17});
    tick();
    check("addr_after_octants", addr_a, 0);
    repeat (4) tick();
    check("halt_count_octants", halt_cnt - h0, 1);
    check("sb_drained_octants", sb_q.size(), 0);

    // Five back-to-back frames with go_master dropped on each halt cycle.
    mon_en = 1'b0;
    load_basic();
    do_reset();
    tick();
    for (int f = 0; f < 5; f++) push_basic();
    h0 = halt_cnt;
    mon_en = 1'b1;
    go_a = 1'b1;
    for (int f = 0; f < 5; f++) begin
      wait_halt_a(200);
      go_a = 1'b0;
      tick();
      if (f < 4) go_a = 1'b1;
    end
    repeat (4) tick();
    check("halt_count_handshake", halt_cnt - h0, 5);
    check("sb_drained_handshake", sb_q.size(), 0);
    mon_en = 1'b0;

    // No END word in a 16-entry ROM: frame ends after address 15.
    go_b = 1'b1;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (halt_b) break;
    end
    check("halt_b_seen", halt_b, 1);
    check("wrap_halt_addr", addr_b, 15);
    check("wrap_last_point", {x_b, y_b}, {8'd16, 8'd31});
    go_b = 1'b0;
    tick();
    check("wrap_addr_reset", addr_b, 0);
    repeat (3) tick();
    go_b = 1'b1;
    tick();
    check("wrap_restart_addr", addr_b, 0);
    tick();
    check("wrap_restart_point", {x_b, y_b}, {8'd1, 8'd1});
    go_b = 1'b0;

    // Reset asserted in the middle of a long line.
    rom_a[1] = word(2'b01, 200, 10);
    go_a = 1'b1;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (x_a == 8'd10) break;
    end
    check("move_reached", {x_a, y_a}, {8'd10, 8'd10});
`ifdef VECTOR_BLANK_EN
    check("blank_move_dwell", blank_a, 1);
`endif
    for (int i = 0; i < 50; i++) begin
      tick();
      if (x_a == 8'd12) break;
    end
    check("line_progress", {x_a, y_a}, {8'd12, 8'd10});
`ifdef VECTOR_BLANK_EN
    check("blank_drawing", blank_a, 0);
`endif
    h0 = halt_cnt;
    rst = 1'b1;
    go_a = 1'b0;
    tick();
    check("rst_mid_line", {addr_a, x_a, y_a, halt_a}, 0);
`ifdef VECTOR_BLANK_EN
    check("blank_after_rst", blank_a, 1);
`endif
    rst = 1'b0;
    repeat (6) tick();
    check("no_halt_after_abort", halt_cnt - h0, 0);
    check("idle_after_abort", {addr_a, x_a, y_a}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
